// File: rtl/spi_alu_pkg.sv
// ============================================================================
// Module      : spi_alu_pkg
// Description : Shared opcode/state types and frame sizing for the SPI ALU link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_alu_pkg;

    localparam int OPCODE_W = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RX_OP  = 3'd1,
        ST_RX_A   = 3'd2,
        ST_RX_B   = 3'd3,
        ST_CALC   = 3'd4,
        ST_TX_RES = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    // Total sclk cycles of one frame: opcode + two operands in, one result out.
    function automatic int frame_len(input int data_w);
        return OPCODE_W + 3 * data_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_pin_sync.sv
// ============================================================================
// Module      : spi_pin_sync
// Description : Synchronizes SPI pins to clk and detects sclk/cs_n edges.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sclk,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_cs_n,
    output logic o_cs_fall,
    output logic o_cs_rise,
    output logic o_mosi
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign o_sclk_rise = ~r_sclk_prev &  r_sclk_sync[SYNC_STAGES-1];
    assign o_sclk_fall =  r_sclk_prev & ~r_sclk_sync[SYNC_STAGES-1];
    assign o_cs_n      =  r_cs_sync[SYNC_STAGES-1];
    assign o_cs_fall   =  r_cs_prev & ~r_cs_sync[SYNC_STAGES-1];
    assign o_cs_rise   = ~r_cs_prev &  r_cs_sync[SYNC_STAGES-1];
    assign o_mosi      =  r_mosi_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi_alu_responder.sv
// ============================================================================
// Module      : spi_alu_responder
// Description : SPI mode-0 slave that receives op/A/B and shifts back the result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_alu_responder
    import spi_alu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sclk,
    input  logic              i_cs_n,
    input  logic              i_mosi,
    output logic              o_miso,
    output logic              o_miso_oe,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_frame_err,
    output logic [DATA_W-1:0] o_last_result
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] c_op_last   = CNT_W'(OPCODE_W - 1);
    localparam logic [CNT_W-1:0] c_word_last = CNT_W'(DATA_W - 1);

    logic w_sclk_rise, w_sclk_fall, w_cs_n, w_cs_fall, w_cs_rise, w_mosi;

    state_e                r_state, w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [OPCODE_W-1:0]   r_op;
    logic [DATA_W-1:0]     r_a, r_b, r_res, r_sh, r_last_result;
    logic [DATA_W-1:0]     w_alu;
    logic                  r_miso, r_done, r_frame_err;
    logic                  w_abort, w_phase_last, w_busy;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_sclk      (i_sclk),
        .i_cs_n      (i_cs_n),
        .i_mosi      (i_mosi),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_cs_n      (w_cs_n),
        .o_cs_fall   (w_cs_fall),
        .o_cs_rise   (w_cs_rise),
        .o_mosi      (w_mosi)
    );

    // Deasserting cs_n mid-frame wins over any coincident sclk edge.
    assign w_abort = w_cs_n &&
                     (r_state inside {ST_RX_OP, ST_RX_A, ST_RX_B, ST_CALC, ST_TX_RES});
    assign w_phase_last = (r_cnt == ((r_state == ST_RX_OP) ? c_op_last : c_word_last));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_cs_fall)                   w_next_state = ST_RX_OP;
                ST_RX_OP:  if (w_sclk_rise && w_phase_last) w_next_state = ST_RX_A;
                ST_RX_A:   if (w_sclk_rise && w_phase_last) w_next_state = ST_RX_B;
                ST_RX_B:   if (w_sclk_rise && w_phase_last) w_next_state = ST_CALC;
                ST_CALC:                                    w_next_state = ST_TX_RES;
                ST_TX_RES: if (w_sclk_rise && w_phase_last) w_next_state = ST_DONE;
                ST_DONE:   if (w_cs_rise)                   w_next_state = ST_IDLE;
                default:                                    w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy    = (r_state != ST_IDLE);
        o_busy    = w_busy;
        o_miso_oe = w_busy;
    end

    always_comb begin
        w_alu = '0;
        case (opcode_e'(r_op))
            OP_ADD:  w_alu = r_a + r_b;
            OP_SUB:  w_alu = r_a - r_b;
            OP_AND:  w_alu = r_a & r_b;
            OP_OR:   w_alu = r_a | r_b;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt         <= '0;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_res         <= '0;
            r_sh          <= '0;
            r_miso        <= 1'b0;
            r_done        <= 1'b0;
            r_frame_err   <= 1'b0;
            r_last_result <= '0;
        end else begin
            r_done      <= 1'b0;
            r_frame_err <= w_abort;

            if (r_state != w_next_state) begin
                r_cnt <= '0;
            end else if (w_sclk_rise &&
                         (r_state inside {ST_RX_OP, ST_RX_A, ST_RX_B, ST_TX_RES})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (!w_abort) begin
                case (r_state)
                    ST_RX_OP: if (w_sclk_rise) r_op <= {r_op[OPCODE_W-2:0], w_mosi};
                    ST_RX_A:  if (w_sclk_rise) r_a  <= {r_a[DATA_W-2:0], w_mosi};
                    ST_RX_B:  if (w_sclk_rise) r_b  <= {r_b[DATA_W-2:0], w_mosi};
                    ST_CALC: begin
                        r_res <= w_alu;
                        r_sh  <= w_alu;
                    end
                    ST_TX_RES: begin
                        if (w_sclk_fall) begin
                            r_miso <= r_sh[DATA_W-1];
                            r_sh   <= {r_sh[DATA_W-2:0], 1'b0};
                        end
                        if (w_sclk_rise && w_phase_last) begin
                            r_done        <= 1'b1;
                            r_last_result <= r_res;
                        end
                    end
                    default: ;
                endcase
            end

            // miso only carries data while the result is being shifted out.
            if (w_next_state != ST_TX_RES) begin
                r_miso <= 1'b0;
            end
        end
    end

    assign o_miso        = r_miso;
    assign o_done        = r_done;
    assign o_frame_err   = r_frame_err;
    assign o_last_result = r_last_result;

endmodule

`default_nettype wire
